// File: rtl/go_game_fsm.sv
// Go game-state controller: validates and commits moves/passes, alternates turns,
// keeps the board and per-colour stone counts, and ends the game on two passes in a row.
module go_game_fsm #(
   parameter int unsigned BOARD_SIZE = 9,
   parameter int unsigned CNT_W      = 9,
   parameter int unsigned STONE_W    = $clog2(BOARD_SIZE*BOARD_SIZE+1)
) (
   input  logic               clk_in,
   input  logic               reset,
   input  logic               move_avail,
   input  logic [7:0]         move,
   output logic               move_ready,
   output logic               move_ack,
   output logic               move_err,
   output logic [1:0]         err_code,
   output logic [1:0]         turn,
   output logic               game_over,
   output logic [CNT_W-1:0]   move_count,
   output logic [STONE_W-1:0] black_stones,
   output logic [STONE_W-1:0] white_stones,
   output logic [7:0]         last_move,
   output logic [1:0]         board [BOARD_SIZE-1:0][BOARD_SIZE-1:0]
);

   localparam int unsigned IDX_W     = (BOARD_SIZE > 1) ? $clog2(BOARD_SIZE) : 1;
   localparam logic [3:0]  BS4       = 4'(BOARD_SIZE);
   localparam logic [7:0]  PASS      = 8'hFF;
   localparam logic [1:0]  EMPTY     = 2'b00;
   localparam logic [1:0]  BLACK     = 2'b01;
   localparam logic [1:0]  WHITE     = 2'b10;
   localparam logic [1:0]  ERR_RANGE = 2'b01;
   localparam logic [1:0]  ERR_OCC   = 2'b10;

   typedef enum logic [1:0] {IDLE, CHECK, OVER} state_e;

   state_e             state_q, state_d;
   logic [7:0]         move_q, move_d;
   logic [1:0]         board_q [BOARD_SIZE-1:0][BOARD_SIZE-1:0];
   logic [1:0]         board_d [BOARD_SIZE-1:0][BOARD_SIZE-1:0];
   logic [1:0]         turn_q, turn_d;
   logic               pass_q, pass_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [STONE_W-1:0] black_q, black_d;
   logic [STONE_W-1:0] white_q, white_d;
   logic [7:0]         last_q, last_d;
   logic               ack_q, ack_d;
   logic               err_q, err_d;
   logic [1:0]         code_q, code_d;
   logic               over_q, over_d;

   logic [3:0]         row, col;
   logic [1:0]         turn_flip;
   logic [CNT_W-1:0]   count_inc;

   assign row       = move_q[7:4];
   assign col       = move_q[3:0];
   assign turn_flip = (turn_q == BLACK) ? WHITE : BLACK;
   assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q <= IDLE;
         move_q  <= 8'h00;
         board_q <= '{default: '{default: EMPTY}};
         turn_q  <= BLACK;
         pass_q  <= 1'b0;
         count_q <= '0;
         black_q <= '0;
         white_q <= '0;
         last_q  <= 8'h00;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= 2'b00;
         over_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         move_q  <= move_d;
         board_q <= board_d;
         turn_q  <= turn_d;
         pass_q  <= pass_d;
         count_q <= count_d;
         black_q <= black_d;
         white_q <= white_d;
         last_q  <= last_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         code_q  <= code_d;
         over_q  <= over_d;
      end
   end

   // Next-state: CHECK resolves pass, range, occupancy, then placement, in that order.
   always_comb begin
      state_d = state_q;
      move_d  = move_q;
      board_d = board_q;
      turn_d  = turn_q;
      pass_d  = pass_q;
      count_d = count_q;
      black_d = black_q;
      white_d = white_q;
      last_d  = last_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      code_d  = 2'b00;
      over_d  = over_q;
      unique case (state_q)
         IDLE: begin
            if (move_avail) begin
               move_d  = move;
               state_d = CHECK;
            end
         end
         CHECK: begin
            state_d = IDLE;
            if (move_q == PASS) begin
               ack_d   = 1'b1;
               turn_d  = turn_flip;
               count_d = count_inc;
               last_d  = PASS;
               pass_d  = 1'b1;
               if (pass_q) begin
                  state_d = OVER;
                  over_d  = 1'b1;
               end
            end else if ((row >= BS4) || (col >= BS4)) begin
               err_d  = 1'b1;
               code_d = ERR_RANGE;
            end else if (board_q[IDX_W'(row)][IDX_W'(col)] != EMPTY) begin
               err_d  = 1'b1;
               code_d = ERR_OCC;
            end else begin
               board_d[IDX_W'(row)][IDX_W'(col)] = turn_q;
               if (turn_q == BLACK) black_d = black_q + STONE_W'(1);
               else                 white_d = white_q + STONE_W'(1);
               turn_d  = turn_flip;
               count_d = count_inc;
               last_d  = move_q;
               pass_d  = 1'b0;
               ack_d   = 1'b1;
            end
         end
         OVER:    state_d = OVER;
         default: state_d = IDLE;
      endcase
   end

   assign move_ready   = (state_q == IDLE) && !reset;
   assign move_ack     = ack_q;
   assign move_err     = err_q;
   assign err_code     = code_q;
   assign turn         = turn_q;
   assign game_over    = over_q;
   assign move_count   = count_q;
   assign black_stones = black_q;
   assign white_stones = white_q;
   assign last_move    = last_q;
   assign board        = board_q;

endmodule

// File: tb/tb_go_game_fsm.sv
// Directed bench for go_game_fsm: a 9x9 default instance and a 13x13 instance
// with a 2-bit saturating move counter.
module tb_go_game_fsm;

   localparam int unsigned S9  = 9;
   localparam int unsigned C9  = 9;
   localparam int unsigned W9  = $clog2(S9*S9+1);
   localparam int unsigned S13 = 13;
   localparam int unsigned C13 = 2;
   localparam int unsigned W13 = $clog2(S13*S13+1);

   logic clk;
   int   checks = 0;
   int   errors = 0;

   logic           reset9, avail9, ready9, ack9, err9, over9;
   logic [7:0]     move9, last9;
   logic [1:0]     code9, turn9;
   logic [C9-1:0]  count9;
   logic [W9-1:0]  black9, white9;
   logic [1:0]     board9 [S9-1:0][S9-1:0];

   logic           reset13, avail13, ready13, ack13, err13, over13;
   logic [7:0]     move13, last13;
   logic [1:0]     code13, turn13;
   logic [C13-1:0] count13;
   logic [W13-1:0] black13, white13;
   logic [1:0]     board13 [S13-1:0][S13-1:0];

   go_game_fsm #(.BOARD_SIZE(S9), .CNT_W(C9)) dut9 (
      .clk_in(clk), .reset(reset9), .move_avail(avail9), .move(move9),
      .move_ready(ready9), .move_ack(ack9), .move_err(err9), .err_code(code9),
      .turn(turn9), .game_over(over9), .move_count(count9),
      .black_stones(black9), .white_stones(white9), .last_move(last9), .board(board9)
   );

   go_game_fsm #(.BOARD_SIZE(S13), .CNT_W(C13)) dut13 (
      .clk_in(clk), .reset(reset13), .move_avail(avail13), .move(move13),
      .move_ready(ready13), .move_ack(ack13), .move_err(err13), .err_code(code13),
      .turn(turn13), .game_over(over13), .move_count(count13),
      .black_stones(black13), .white_stones(white13), .last_move(last13), .board(board13)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present a move for one cycle, return #1 after the commit edge.
   task automatic mv9(input logic [7:0] m);
      @(negedge clk); avail9 = 1'b1; move9 = m;
      @(posedge clk); #1 avail9 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic mv13(input logic [7:0] m);
      @(negedge clk); avail13 = 1'b1; move13 = m;
      @(posedge clk); #1 avail13 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic rst9();
      @(negedge clk); reset9 = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      @(negedge clk); reset9 = 1'b0;
   endtask

   initial begin
      reset9 = 1'b1; avail9 = 1'b0; move9 = 8'h00;
      reset13 = 1'b1; avail13 = 1'b0; move13 = 8'h00;
      @(posedge clk); @(posedge clk); #1;
      check("rst_turn", 32'(turn9), 32'h1);
      check("rst_count", 32'(count9), 32'h0);
      check("rst_last", 32'(last9), 32'h0);
      check("rst_ack_err", 32'({ack9, err9, code9}), 32'h0);
      check("rst_over", 32'(over9), 32'h0);
      check("rst_ready_low", 32'(ready9), 32'h0);
      check("rst_stones", 32'({black9, white9}), 32'h0);
      @(negedge clk); reset9 = 1'b0; reset13 = 1'b0;
      #1 check("ready_after_rst", 32'(ready9), 32'h1);

      // Plain stone placement
      mv9(8'h33);
      check("t1_board33", 32'(board9[3][3]), 32'h1);
      check("t1_ack", 32'(ack9), 32'h1);
      check("t1_err", 32'(err9), 32'h0);
      check("t1_ready", 32'(ready9), 32'h1);
      check("t1_turn", 32'(turn9), 32'h2);
      check("t1_black", 32'(black9), 32'h1);
      check("t1_count", 32'(count9), 32'h1);
      check("t1_last", 32'(last9), 32'h33);
      @(posedge clk); #1 check("t1_ack_pulse", 32'(ack9), 32'h0);

      // Occupied cell
      mv9(8'h33);
      check("t2_err", 32'(err9), 32'h1);
      check("t2_code", 32'(code9), 32'h2);
      check("t2_ack", 32'(ack9), 32'h0);
      check("t2_turn", 32'(turn9), 32'h2);
      check("t2_count", 32'(count9), 32'h1);
      check("t2_board33", 32'(board9[3][3]), 32'h1);
      @(posedge clk); #1 check("t2_code_clear", 32'({err9, code9}), 32'h0);

      // Range errors, then edge column
      mv9(8'h09);
      check("t3_code_col", 32'(code9), 32'h1);
      mv9(8'hF0);
      check("t3_code_F0", 32'(code9), 32'h1);
      check("t3_last_kept", 32'(last9), 32'h33);
      mv9(8'h08);
      check("t3_board08", 32'(board9[0][8]), 32'h2);
      check("t3_ack", 32'(ack9), 32'h1);
      check("t3_white", 32'(white9), 32'h1);
      check("t3_turn", 32'(turn9), 32'h1);
      check("t3_count", 32'(count9), 32'h2);

      // Pass, stone, pass keeps the game alive
      mv9(8'hFF);
      check("t4_pass_ack", 32'(ack9), 32'h1);
      check("t4_pass_last", 32'(last9), 32'hFF);
      check("t4_pass_turn", 32'(turn9), 32'h2);
      mv9(8'h11);
      check("t4_board11", 32'(board9[1][1]), 32'h2);
      check("t4_white", 32'(white9), 32'h2);
      mv9(8'hFF);
      check("t4_over_low", 32'(over9), 32'h0);
      check("t4_count5", 32'(count9), 32'h5);
      check("t4_ready", 32'(ready9), 32'h1);

      // Second consecutive pass ends the game
      mv9(8'hFF);
      check("t4_over", 32'(over9), 32'h1);
      check("t4_ready_low", 32'(ready9), 32'h0);
      check("t4_count6", 32'(count9), 32'h6);
      check("t4_turn6", 32'(turn9), 32'h1);
      mv9(8'h00);
      @(posedge clk); #1;
      check("t4_ign_board00", 32'(board9[0][0]), 32'h0);
      check("t4_ign_count", 32'(count9), 32'h6);
      check("t4_ign_ackerr", 32'({ack9, err9}), 32'h0);
      check("t4_over_held", 32'(over9), 32'h1);

      // Reset during CHECK cancels the move
      rst9();
      mv9(8'h22);
      check("t5_pre_turn", 32'(turn9), 32'h2);
      @(negedge clk); avail9 = 1'b1; move9 = 8'h44;
      @(posedge clk); #1 avail9 = 1'b0; reset9 = 1'b1;
      @(posedge clk); #1;
      check("t5_ackerr", 32'({ack9, err9}), 32'h0);
      check("t5_board44", 32'(board9[4][4]), 32'h0);
      check("t5_board22", 32'(board9[2][2]), 32'h0);
      check("t5_turn", 32'(turn9), 32'h1);
      check("t5_count", 32'(count9), 32'h0);
      @(negedge clk); reset9 = 1'b0;
      #1 check("t5_ready", 32'(ready9), 32'h1);
      @(posedge clk); #1 check("t5_no_late_ack", 32'({ack9, err9}), 32'h0);

      // 13x13 board, 2-bit saturating counter
      mv13(8'h00);
      check("t6_turn1", 32'(turn13), 32'h2);
      check("t6_count1", 32'(count13), 32'h1);
      mv13(8'hCC);
      check("t6_boardCC", 32'(board13[12][12]), 32'h2);
      check("t6_turn2", 32'(turn13), 32'h1);
      mv13(8'h01);
      check("t6_count3", 32'(count13), 32'h3);
      check("t6_turn3", 32'(turn13), 32'h2);
      mv13(8'h02);
      check("t6_count_sat", 32'(count13), 32'h3);
      check("t6_turn4", 32'(turn13), 32'h1);
      check("t6_black", 32'(black13), 32'h2);
      mv13(8'hD0);
      check("t6_row13_err", 32'({err13, code13}), 32'h5);
      check("t6_row13_count", 32'(count13), 32'h3);
      check("t6_over", 32'(over13), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
